// File: rtl/pipe_feeder.sv
// pipe_feeder: command FIFO that issues entries to a credit-controlled pipeline
module pipe_feeder #(
    parameter int DEPTH   = 4,
    parameter int CREDITS = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [1:0]               s_data,
    input  logic                     s_action,
    output logic                     pipe_vld,
    output logic [1:0]               pipe_data,
    output logic                     pipe_action,
    input  logic                     credit_ret,
    output logic [$clog2(DEPTH):0]   fifo_cnt,
    output logic [2:0]               credit_cnt,
    output logic [1:0]               state,
    output logic                     cred_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [2:0] CRED_MAX = 3'(CREDITS);

    typedef enum logic [1:0] {EMPTY = 2'd0, ISSUE = 2'd1, STALL = 2'd2} state_t;

    state_t         r_state, w_state_nxt;
    logic [2:0]     r_mem [DEPTH];
    logic [AW-1:0]  r_wp, r_rp;
    logic [CW-1:0]  r_cnt, w_cnt_nxt;
    logic [2:0]     r_cred, w_cred_nxt;
    logic           r_err, w_err_nxt;
    logic           r_vld, r_act;
    logic [1:0]     r_data;
    logic           w_push, w_issue;

    // Full FIFO refuses input even when a pop happens in the same cycle
    assign s_ready = rst_n && (r_cnt < FULL);
    assign w_push  = s_valid && s_ready;
    assign w_issue = (r_cnt != '0) && (r_cred != '0);

    // Next occupancy, credit count, overflow flag and FSM state
    always_comb begin
        w_cnt_nxt  = r_cnt + CW'(w_push) - CW'(w_issue);
        w_cred_nxt = r_cred;
        w_err_nxt  = r_err;
        if (credit_ret && !w_issue) begin
            if (r_cred == CRED_MAX)
                w_err_nxt = 1'b1;
            else
                w_cred_nxt = r_cred + 3'd1;
        end else if (w_issue && !credit_ret) begin
            w_cred_nxt = r_cred - 3'd1;
        end
        w_state_nxt = (w_cnt_nxt == '0) ? EMPTY : (w_cred_nxt == '0) ? STALL : ISSUE;
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n)
            r_state <= EMPTY;
        else
            r_state <= w_state_nxt;
    end

    // Entry storage; s_ready is low during reset so nothing is written then
    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wp] <= {s_action, s_data};
    end

    // Pointers, counters and the registered pipeline interface
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wp   <= '0;
            r_rp   <= '0;
            r_cnt  <= '0;
            r_cred <= CRED_MAX;
            r_err  <= 1'b0;
            r_vld  <= 1'b0;
            r_data <= '0;
            r_act  <= 1'b0;
        end else begin
            r_cnt  <= w_cnt_nxt;
            r_cred <= w_cred_nxt;
            r_err  <= w_err_nxt;
            r_vld  <= w_issue;
            if (w_push)
                r_wp <= r_wp + AW'(1);
            if (w_issue) begin
                r_rp            <= r_rp + AW'(1);
                {r_act, r_data} <= r_mem[r_rp];
            end
        end
    end

    assign pipe_vld    = r_vld;
    assign pipe_data   = r_data;
    assign pipe_action = r_act;
    assign fifo_cnt    = r_cnt;
    assign credit_cnt  = r_cred;
    assign state       = r_state;
    assign cred_err    = r_err;
endmodule
